// File: rtl/car_anti_theft_alarm_system.sv
`default_nettype none
// ============================================================================
// Module   : car_anti_theft_alarm_system
// Brief    : Door-watching alarm FSM with entry delay, auto-arming and a
//            hidden-switch fuel-pump interlock. Optional macro:
//            CATAS_STATUS_BLINK_EN (status LED blinks while ARMED).
// Revision : 1.0 - initial release
// ============================================================================
module car_anti_theft_alarm_system #(
    parameter int TICK_DIV        = 1,
    parameter int TIMER_W         = 8,
    parameter int ARM_DELAY       = 6,
    parameter int DRIVER_DELAY    = 8,
    parameter int PASSENGER_DELAY = 15,
    parameter int ALARM_ON        = 10
) (
    input  logic clock,
    input  logic systemReset,
    input  logic ignition,
    input  logic brake,
    input  logic hidden,
    input  logic driver,
    input  logic passenger,
    output logic fuelPumpPower,
    output logic statusIndicator,
    output logic siren
);

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGERED  = 3'd1,
        ST_SOUNDING   = 3'd2,
        ST_DISARMED   = 3'd3,
        ST_WAIT_OPEN  = 3'd4,
        ST_WAIT_CLOSE = 3'd5,
        ST_ARMING     = 3'd6
    } state_t;

    localparam logic [TIMER_W-1:0] c_one     = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] c_arm_ld  = TIMER_W'(ARM_DELAY);
    localparam logic [TIMER_W-1:0] c_drv_ld  = TIMER_W'(DRIVER_DELAY);
    localparam logic [TIMER_W-1:0] c_pas_ld  = TIMER_W'(PASSENGER_DELAY);
    localparam logic [TIMER_W-1:0] c_alrm_ld = TIMER_W'(ALARM_ON);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pump_en_q, pump_en_d;
    logic               w_tick;
    logic               w_expire;
    logic               w_door_open;
    logic               w_armed_led;

    generate
        if (TICK_DIV <= 1) begin : g_tick_every_cycle
            assign w_tick = 1'b1;
        end else begin : g_prescaler
            localparam int PW = $clog2(TICK_DIV);
            logic [PW-1:0] presc_q, presc_d;

            assign w_tick = (presc_q == PW'(TICK_DIV - 1));

            always_comb begin
                presc_d = w_tick ? '0 : presc_q + 1'b1;
            end

            always_ff @(posedge clock or negedge systemReset) begin
                if (!systemReset) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_d;
                end
            end
        end
    endgenerate

    assign w_expire    = w_tick && (timer_q == c_one);
    assign w_door_open = !driver || !passenger;

    // Ignition overrides every state; timed states count down on ticks only.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (ignition) begin
            state_d = ST_DISARMED;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (!driver) begin
                        state_d = ST_TRIGGERED;
                        timer_d = c_drv_ld;
                    end else if (!passenger) begin
                        state_d = ST_TRIGGERED;
                        timer_d = c_pas_ld;
                    end
                end
                ST_TRIGGERED: begin
                    if (w_expire) begin
                        state_d = ST_SOUNDING;
                        timer_d = c_alrm_ld;
                    end else if (w_tick) begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_SOUNDING: begin
                    if (w_door_open) begin
                        timer_d = c_alrm_ld;
                    end else if (w_expire) begin
                        state_d = ST_ARMED;
                        timer_d = '0;
                    end else if (w_tick) begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_DISARMED: begin
                    state_d = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (!driver) begin
                        state_d = ST_WAIT_CLOSE;
                    end
                end
                ST_WAIT_CLOSE: begin
                    if (!w_door_open) begin
                        state_d = ST_ARMING;
                        timer_d = c_arm_ld;
                    end
                end
                ST_ARMING: begin
                    if (w_door_open) begin
                        state_d = ST_WAIT_CLOSE;
                        timer_d = '0;
                    end else if (w_expire) begin
                        state_d = ST_ARMED;
                        timer_d = '0;
                    end else if (w_tick) begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Pump latch: armed only by the secret sequence while disarmed, dropped with the key.
    always_comb begin
        pump_en_d = ignition &&
                    (pump_en_q || (brake && hidden && (state_q == ST_DISARMED)));
    end

    always_ff @(posedge clock or negedge systemReset) begin
        if (!systemReset) begin
            state_q   <= ST_ARMED;
            timer_q   <= '0;
            pump_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pump_en_q <= pump_en_d;
        end
    end

`ifdef CATAS_STATUS_BLINK_EN
    logic blink_q, blink_d;

    // Phase restarts at 1 on every ARMED entry, then flips per tick.
    always_comb begin
        blink_d = 1'b1;
        if ((state_d == ST_ARMED) && (state_q == ST_ARMED)) begin
            blink_d = w_tick ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge clock or negedge systemReset) begin
        if (!systemReset) begin
            blink_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign w_armed_led = blink_q;
`else
    assign w_armed_led = 1'b1;
`endif

    assign siren           = (state_q == ST_SOUNDING);
    assign statusIndicator = (state_q == ST_TRIGGERED) || (state_q == ST_SOUNDING) ||
                             ((state_q == ST_ARMED) && w_armed_led);
    assign fuelPumpPower   = pump_en_q && ignition;

endmodule
`default_nettype wire

// File: tb/tb_car_anti_theft_alarm_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_anti_theft_alarm_system
// Brief    : Directed + randomized bench against a deadline-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_car_anti_theft_alarm_system;

    logic clock = 1'b0;
    logic systemReset;
    logic ignition, brake, hidden, driver, passenger;
    logic fuelPumpPower, statusIndicator, siren;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    car_anti_theft_alarm_system dut (
        .clock           (clock),
        .systemReset     (systemReset),
        .ignition        (ignition),
        .brake           (brake),
        .hidden          (hidden),
        .driver          (driver),
        .passenger       (passenger),
        .fuelPumpPower   (fuelPumpPower),
        .statusIndicator (statusIndicator),
        .siren           (siren)
    );

    // Reference: mode plus absolute edge number at which the current delay ends.
    typedef enum {M_ARMED, M_TRIG, M_SOUND, M_DIS, M_WOPEN, M_WCLOSE, M_ARMING} mode_t;
    mode_t mode;
    int    n;
    int    deadline;
    int    armed_since;
    bit    pump;

    task automatic check_value(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode        = M_ARMED;
        pump        = 1'b0;
        deadline    = 0;
        armed_since = n;
    endtask

    task automatic model_edge();
        mode_t prev;
        bit    open_any;
        n++;
        prev     = mode;
        open_any = !driver || !passenger;
        pump = ignition && (pump || (brake && hidden && mode == M_DIS));
        if (ignition) begin
            mode = M_DIS;
        end else begin
            case (mode)
                M_ARMED:  if (!driver) begin mode = M_TRIG; deadline = n + 8; end
                          else if (!passenger) begin mode = M_TRIG; deadline = n + 15; end
                M_TRIG:   if (n == deadline) begin mode = M_SOUND; deadline = n + 10; end
                M_SOUND:  if (open_any) deadline = n + 10;
                          else if (n == deadline) mode = M_ARMED;
                M_DIS:    mode = M_WOPEN;
                M_WOPEN:  if (!driver) mode = M_WCLOSE;
                M_WCLOSE: if (!open_any) begin mode = M_ARMING; deadline = n + 6; end
                M_ARMING: if (open_any) mode = M_WCLOSE;
                          else if (n == deadline) mode = M_ARMED;
                default:  mode = M_ARMED;
            endcase
        end
        if (mode == M_ARMED && prev != M_ARMED) armed_since = n;
    endtask

    function automatic int exp_led();
        case (mode)
            M_TRIG, M_SOUND: return 1;
`ifdef CATAS_STATUS_BLINK_EN
            M_ARMED:         return ((n - armed_since) % 2 == 0) ? 1 : 0;
`else
            M_ARMED:         return 1;
`endif
            default:         return 0;
        endcase
    endfunction

    // Starts and ends on a falling edge.
    task automatic cycle(input bit ign, input bit brk, input bit hid,
                         input bit drv, input bit pas);
        ignition  = ign;
        brake     = brk;
        hidden    = hid;
        driver    = drv;
        passenger = pas;
        #1;
        check_value("pump_comb", int'(fuelPumpPower), int'(pump && ign));
        @(posedge clock);
        model_edge();
        #1;
        check_value("siren", int'(siren), int'(mode == M_SOUND));
        check_value("status", int'(statusIndicator), exp_led());
        check_value("pump", int'(fuelPumpPower), int'(pump && ignition));
        @(negedge clock);
    endtask

    task automatic do_async_reset();
        #2 systemReset = 1'b0;
        #1;
        check_value("rst_siren", int'(siren), 0);
        check_value("rst_pump", int'(fuelPumpPower), 0);
        check_value("rst_status", int'(statusIndicator), 1);
        @(posedge clock);
        @(negedge clock);
        systemReset = 1'b1;
        model_reset();
    endtask

    int k;
    bit r_ign, r_brk, r_hid, r_drv, r_pas;

    initial begin
        n = 0;
        systemReset = 1'b0;
        ignition = 1'b0; brake = 1'b0; hidden = 1'b0;
        driver = 1'b1; passenger = 1'b1;
        model_reset();
        #1;
        check_value("por_siren", int'(siren), 0);
        check_value("por_pump", int'(fuelPumpPower), 0);
        check_value("por_status", int'(statusIndicator), 1);
        @(negedge clock);
        @(negedge clock);
        systemReset = 1'b1;

        // Disarm and fuel-pump sequence
        cycle(1, 0, 0, 1, 1);
        check_value("dis_status", int'(statusIndicator), 0);
        cycle(1, 1, 0, 1, 1);
        check_value("brake_only", int'(fuelPumpPower), 0);
        cycle(1, 1, 1, 1, 1);
        check_value("pump_set", int'(fuelPumpPower), 1);
        cycle(1, 0, 0, 1, 1);
        check_value("pump_hold", int'(fuelPumpPower), 1);
        cycle(0, 0, 0, 1, 1);
        check_value("pump_off", int'(fuelPumpPower), 0);

        // Auto-arm with a reopen partway through
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        k = 0;
        while (statusIndicator !== 1'b1 && k < 40) begin cycle(0, 0, 0, 1, 1); k++; end
        check_value("arm_edges", k, 6);

        // Driver entry delay, then alarm hold with doors closed
        cycle(0, 0, 0, 0, 1);
        k = 0;
        while (siren !== 1'b1 && k < 40) begin cycle(0, 0, 0, 1, 1); k++; end
        check_value("driver_delay", k, 8);
        k = 0;
        while (siren === 1'b1 && k < 40) begin cycle(0, 0, 0, 1, 1); k++; end
        check_value("alarm_hold", k, 10);

        // Passenger entry delay, then long open door in SOUNDING
        cycle(0, 0, 0, 1, 0);
        k = 0;
        while (siren !== 1'b1 && k < 40) begin cycle(0, 0, 0, 1, 1); k++; end
        check_value("pass_delay", k, 15);
        repeat (20) cycle(0, 0, 0, 0, 1);
        check_value("held_open_siren", int'(siren), 1);
        k = 0;
        while (siren === 1'b1 && k < 40) begin cycle(0, 0, 0, 1, 1); k++; end
        check_value("close_drop", k, 10);
        check_value("rearmed", int'(statusIndicator), 1);

        // Both doors on one edge: driver delay wins
        cycle(0, 0, 0, 0, 0);
        k = 0;
        while (siren !== 1'b1 && k < 40) begin cycle(0, 0, 0, 1, 1); k++; end
        check_value("both_doors", k, 8);

        // Reset during SOUNDING
        do_async_reset();

        // Ignition during TRIGGERED
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 1);
        check_value("trig_ign_siren", int'(siren), 0);
        check_value("trig_ign_status", int'(statusIndicator), 0);

        // Ignition together with a door open during SOUNDING
        do_async_reset();
        cycle(0, 0, 0, 0, 1);
        repeat (9) cycle(0, 0, 0, 1, 1);
        check_value("pre_ign_siren", int'(siren), 1);
        cycle(1, 0, 0, 0, 1);
        check_value("snd_ign_siren", int'(siren), 0);
        check_value("snd_ign_status", int'(statusIndicator), 0);

        // Randomized traffic with slowly changing inputs
        r_ign = 1'b1; r_brk = 1'b0; r_hid = 1'b0; r_drv = 1'b1; r_pas = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 3)  r_ign = ~r_ign;
            if ($urandom_range(99) < 20) r_brk = ~r_brk;
            if ($urandom_range(99) < 20) r_hid = ~r_hid;
            if ($urandom_range(99) < (r_drv ? 5 : 30)) r_drv = ~r_drv;
            if ($urandom_range(99) < (r_pas ? 4 : 30)) r_pas = ~r_pas;
            if ($urandom_range(999) < 2) do_async_reset();
            else cycle(r_ign, r_brk, r_hid, r_drv, r_pas);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
